// File: rtl/sync_pkg.sv
// Purpose: shared defaults and width helper for the input conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a (no data path).
package sync_pkg;

  // Default synchroniser depth and debounce window
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_DEF    = 16;

  // Width of a counter that must hold values 0..debounce
  function automatic int cnt_width(input int debounce);
    return $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// Purpose: one channel - synchroniser chain, debounce filter, rise/fall pulse registers.
// Latency: STAGES+DEBOUNCE clock edges from a steady raw step to o_signal/pulse.
// Backpressure: none; free-running, pulses are single-cycle and unconditional.
module debounce_cell
  import sync_pkg::*;
#(
  parameter int   STAGES    = SYNC_STAGES_DEF,
  parameter int   DEBOUNCE  = DEBOUNCE_DEF,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_signal,
  output logic o_signal,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW       = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [STAGES-1:0] sync;
  logic              s;
  logic              stable;
  logic [CW-1:0]     cnt;

  logic              stable_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic              rise_nxt;
  logic              fall_nxt;

  assign s        = sync[STAGES-1];
  assign o_signal = stable;

  // Synchroniser: shift the raw pin through STAGES flops
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync <= {STAGES{RESET_VAL}};
    end else begin
      sync <= {sync[STAGES-2:0], i_signal};
    end
  end

  // Filter next state: count while s disagrees, accept on the last count, drop count on any return
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = '0;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    if (s != stable) begin
      if (cnt == CNT_LAST) begin
        stable_nxt = s;
        rise_nxt   = s;
        fall_nxt   = ~s;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Filter state and registered pulses; reset abandons any partial count silently
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stable <= RESET_VAL;
      cnt    <= '0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      stable <= stable_nxt;
      cnt    <= cnt_nxt;
      o_rise <= rise_nxt;
      o_fall <= fall_nxt;
    end
  end

endmodule

// File: rtl/sync_debounce.sv
// Purpose: WIDTH independent channels of synchronise + debounce + edge detect.
// Latency: STAGES+DEBOUNCE clock edges per channel; all outputs registered.
// Backpressure: none; every accepted edge produces exactly one single-cycle pulse.
module sync_debounce
  import sync_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               STAGES    = SYNC_STAGES_DEF,
  parameter int               DEBOUNCE  = DEBOUNCE_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_signal,
  output logic [WIDTH-1:0] o_signal,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  for (genvar n = 0; n < WIDTH; n++) begin : g_ch
    debounce_cell #(
      .STAGES    (STAGES),
      .DEBOUNCE  (DEBOUNCE),
      .RESET_VAL (RESET_VAL[n])
    ) u_cell (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_signal (i_signal[n]),
      .o_signal (o_signal[n]),
      .o_rise   (o_rise[n]),
      .o_fall   (o_fall[n])
    );
  end

endmodule
